// File: rtl/sobel_hls_luma_accum.sv
// Purpose : sums the three per-channel luma products of one pixel, rounds half-up,
//           drops FRAC_BITS fractional bits and saturates to an OUT_WIDTH-bit luma sample.
// Latency : 2 cycles from input transfer to m_valid; 1 pixel/clock sustained.
// Backpr. : s_ready = m_ready | ~v2 | ~v1, so bubbles always fill; with both stages full
//           and m_ready low, nothing moves and the output holds stable.
//
// Ports:
//   ap_clk, ap_rst_n              clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready               input handshake
//   s_prod_r/g/b                  unsigned channel products, PROD_WIDTH bits each
//   s_last/s_user                 sideband (end-of-line / start-of-frame), carried with the pixel
//   m_valid/m_ready               output handshake
//   m_data, m_last, m_user        luma sample plus its aligned sideband
//   sat_clr                       synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt                       count of saturated output transfers, sticks at all-ones
module sobel_hls_luma_accum #(
   parameter int PROD_WIDTH = 29,
   parameter int FRAC_BITS  = 21,
   parameter int OUT_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [PROD_WIDTH-1:0] s_prod_r,
   input  logic [PROD_WIDTH-1:0] s_prod_g,
   input  logic [PROD_WIDTH-1:0] s_prod_b,
   input  logic                  s_last,
   input  logic                  s_user,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_last,
   output logic                  m_user,
   input  logic                  sat_clr,
   output logic [CNT_WIDTH-1:0]  sat_cnt
);

   localparam int L_SW = PROD_WIDTH + 1;   // partial sum / held blue width
   localparam int L_TW = PROD_WIDTH + 2;   // full sum width; three products plus half never overflow
   localparam logic [L_TW-1:0] L_HALF = L_TW'(1) << (FRAC_BITS - 1);

   // Stage 1 registers
   logic                 r_v1;
   logic [L_SW-1:0]      r_psum;
   logic [L_SW-1:0]      r_b;
   logic                 r_last1;
   logic                 r_user1;

   // Stage 2 registers
   logic                 r_v2;
   logic [OUT_WIDTH-1:0] r_data;
   logic                 r_last2;
   logic                 r_user2;
   logic                 r_sat2;    // the value held in r_data was clipped
   logic [CNT_WIDTH-1:0] r_sat_cnt;

   logic                 w_adv1;
   logic                 w_adv2;
   logic [L_SW-1:0]      w_psum;
   logic [L_TW-1:0]      w_tot;
   logic [L_TW-1:0]      w_q;
   logic                 w_sat;
   logic                 w_m_fire;

   // Advance terms depend only on m_ready and the stage valids, never on s_valid.
   assign w_adv2   = m_ready | ~r_v2;
   assign w_adv1   = w_adv2 | ~r_v1;
   assign s_ready  = w_adv1;
   assign w_m_fire = r_v2 & m_ready;

   assign w_psum = {1'b0, s_prod_r} + {1'b0, s_prod_g};
   assign w_tot  = {1'b0, r_psum} + {1'b0, r_b} + L_HALF;
   assign w_q    = w_tot >> FRAC_BITS;
   // Any set bit above the output width means the rounded value exceeds the output range.
   assign w_sat  = |w_q[L_TW-1:OUT_WIDTH];

   // Stage 1: first adder level plus sideband capture
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v1    <= 1'b0;
         r_psum  <= '0;
         r_b     <= '0;
         r_last1 <= 1'b0;
         r_user1 <= 1'b0;
      end else if (w_adv1) begin
         r_v1 <= s_valid;
         if (s_valid) begin
            r_psum  <= w_psum;
            r_b     <= {1'b0, s_prod_b};
            r_last1 <= s_last;
            r_user1 <= s_user;
         end
      end
   end

   // Stage 2: final add with rounding, shift and clip. Data only loads with a real pixel
   // so the output register never picks up bubble contents.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v2    <= 1'b0;
         r_data  <= '0;
         r_last2 <= 1'b0;
         r_user2 <= 1'b0;
         r_sat2  <= 1'b0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_data  <= w_sat ? {OUT_WIDTH{1'b1}} : w_q[OUT_WIDTH-1:0];
            r_last2 <= r_last1;
            r_user2 <= r_user1;
            r_sat2  <= w_sat;
         end
      end
   end

   // Saturation counter: counts accepted clipped pixels, clear has priority, sticks at max.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_sat_cnt <= '0;
      end else if (sat_clr) begin
         r_sat_cnt <= '0;
      end else if (w_m_fire && r_sat2 && (r_sat_cnt != {CNT_WIDTH{1'b1}})) begin
         r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
      end
   end

   assign m_valid = r_v2;
   assign m_data  = r_data;
   assign m_last  = r_last2;
   assign m_user  = r_user2;
   assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_sobel_hls_luma_accum.sv
// Bench for sobel_hls_luma_accum: table of single-pixel vectors with hand-computed luma,
// followed by directed sequences for clear priority, stalled streaming, backpressure fill
// and asynchronous reset mid-stream.
module tb_sobel_hls_luma_accum;

   localparam int PW = 29;
   localparam int OW = 8;
   localparam int CW = 16;

   logic          ap_clk;
   logic          ap_rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [PW-1:0] s_prod_r;
   logic [PW-1:0] s_prod_g;
   logic [PW-1:0] s_prod_b;
   logic          s_last;
   logic          s_user;
   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0] m_data;
   logic          m_last;
   logic          m_user;
   logic          sat_clr;
   logic [CW-1:0] sat_cnt;

   int n_tests;
   int n_fail;
   int exp_sat;

   sobel_hls_luma_accum #(
      .PROD_WIDTH(PW), .FRAC_BITS(21), .OUT_WIDTH(OW), .CNT_WIDTH(CW)
   ) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_prod_r (s_prod_r),
      .s_prod_g (s_prod_g),
      .s_prod_b (s_prod_b),
      .s_last   (s_last),
      .s_user   (s_user),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_user   (m_user),
      .sat_clr  (sat_clr),
      .sat_cnt  (sat_cnt)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [PW-1:0] r;
      logic [PW-1:0] g;
      logic [PW-1:0] b;
      logic          last;
      logic          user;
      logic [OW-1:0] exp_data;
      logic          exp_sat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1 ns later.
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Push one pixel with m_ready high and let it drain completely.
   task automatic send_one(input logic [PW-1:0] r, input logic [PW-1:0] g, input logic [PW-1:0] b);
      m_ready  = 1'b1;
      s_valid  = 1'b1;
      s_prod_r = r;
      s_prod_g = g;
      s_prod_b = b;
      tick();
      s_valid = 1'b0;
      tick();
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      exp_sat  = 0;
      ap_rst_n = 1'b0;
      s_valid  = 1'b0;
      s_prod_r = '0;
      s_prod_g = '0;
      s_prod_b = '0;
      s_last   = 1'b0;
      s_user   = 1'b0;
      m_ready  = 1'b0;
      sat_clr  = 1'b0;

      //            r              g             b              last  user  data  sat
      vecs[0] = '{PW'(100 << 21), '0,           PW'(1 << 20),     1'b0, 1'b0, 8'd101, 1'b0};
      vecs[1] = '{PW'(100 << 21), '0,           PW'((1 << 20) - 1), 1'b1, 1'b0, 8'd100, 1'b0};
      vecs[2] = '{PW'(1 << 28),   PW'(1 << 28), PW'(1 << 28),     1'b0, 1'b1, 8'd255, 1'b1};
      vecs[3] = '{'0,             '0,           '0,               1'b1, 1'b1, 8'd0,   1'b0};
      vecs[4] = '{PW'((255 << 21) + (1 << 20) - 1), '0, '0,       1'b0, 1'b0, 8'd255, 1'b0};
      vecs[5] = '{PW'(255 << 21), '0,           PW'(1 << 20),     1'b0, 1'b0, 8'd255, 1'b1};
      vecs[6] = '{PW'(10 << 21),  PW'(20 << 21), PW'(30 << 21),   1'b1, 1'b0, 8'd60,  1'b0};
      vecs[7] = '{{PW{1'b1}},     {PW{1'b1}},   {PW{1'b1}},       1'b0, 1'b1, 8'd255, 1'b1};

      // Reset release
      #22;
      ap_rst_n = 1'b1;
      tick();
      #1;
      chk("rst_s_ready", 32'(s_ready), 1);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data",  32'(m_data),  0);
      chk("rst_sat_cnt", 32'(sat_cnt), 0);

      // Table vectors: 2-cycle latency, data/sideband, saturation counting
      for (int i = 0; i < 8; i++) begin
         m_ready  = 1'b1;
         s_valid  = 1'b1;
         s_prod_r = vecs[i].r;
         s_prod_g = vecs[i].g;
         s_prod_b = vecs[i].b;
         s_last   = vecs[i].last;
         s_user   = vecs[i].user;
         #1;
         chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 1);
         tick();
         s_valid = 1'b0;
         s_last  = 1'b0;
         s_user  = 1'b0;
         #1;
         chk($sformatf("v%0d_lat1_m_valid", i), 32'(m_valid), 0);
         tick();
         #1;
         chk($sformatf("v%0d_lat2_m_valid", i), 32'(m_valid), 1);
         chk($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_last", i), 32'(m_last), 32'(vecs[i].last));
         chk($sformatf("v%0d_user", i), 32'(m_user), 32'(vecs[i].user));
         tick();
         #1;
         if (vecs[i].exp_sat) exp_sat++;
         chk($sformatf("v%0d_sat_cnt", i), 32'(sat_cnt), 32'(exp_sat));
         chk($sformatf("v%0d_drained", i), 32'(m_valid), 0);
      end

      // Saturating pixel accepted on the same edge as sat_clr: clear wins
      m_ready  = 1'b1;
      s_valid  = 1'b1;
      s_prod_r = PW'(1 << 28);
      s_prod_g = PW'(1 << 28);
      s_prod_b = PW'(1 << 28);
      tick();
      s_valid = 1'b0;
      tick();
      chk("clr_pre_m_valid", 32'(m_valid), 1);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      exp_sat = 0;
      #1;
      chk("clr_priority_sat_cnt", 32'(sat_cnt), 32'(exp_sat));

      // Stream 0..7 with m_ready toggling; check order, last, and stability while stalled
      begin
         int          sent;
         int          rcvd;
         int          stab_err;
         logic        hold;
         logic [OW-1:0] hold_d;
         logic        fire_s;
         sent = 0; rcvd = 0; stab_err = 0; hold = 1'b0; hold_d = '0;
         s_prod_g = '0;
         s_prod_b = '0;
         for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            m_ready  = (cyc % 2 == 0);
            s_valid  = (sent < 8);
            s_prod_r = PW'(sent * (1 << 21));
            s_last   = (sent == 7);
            #1;
            if (hold && (!m_valid || m_data !== hold_d)) stab_err++;
            fire_s = s_valid && s_ready;
            if (m_valid && m_ready) begin
               chk($sformatf("stream_data%0d", rcvd), 32'(m_data), 32'(rcvd));
               chk($sformatf("stream_last%0d", rcvd), 32'(m_last), 32'(rcvd == 7));
               rcvd++;
               hold = 1'b0;
            end else if (m_valid) begin
               hold   = 1'b1;
               hold_d = m_data;
            end else begin
               hold = 1'b0;
            end
            tick();
            if (fire_s) sent++;
         end
         s_valid = 1'b0;
         s_last  = 1'b0;
         chk("stream_rcvd", 32'(rcvd), 8);
         chk("stream_stable", 32'(stab_err), 0);
      end

      // Backpressure fill: 5 stalled cycles accept exactly 2 pixels
      tick();
      tick();
      begin
         int   acc;
         logic fire;
         acc = 0;
         m_ready = 1'b0;
         for (int c = 0; c < 5; c++) begin
            s_valid  = 1'b1;
            s_prod_r = PW'((20 + acc) * (1 << 21));
            #1;
            fire = s_ready;
            tick();
            if (fire) acc++;
         end
         #1;
         chk("bp_accepted", 32'(acc), 2);
         chk("bp_s_ready_low", 32'(s_ready), 0);
         m_ready = 1'b1;
         s_valid = 1'b0;
         #1;
         chk("bp_s_ready_release", 32'(s_ready), 1);
         chk("bp_drain0", 32'(m_data), 20);
         tick();
         #1;
         chk("bp_drain1_valid", 32'(m_valid), 1);
         chk("bp_drain1", 32'(m_data), 21);
         tick();
         #1;
         chk("bp_empty", 32'(m_valid), 0);
      end

      // Asynchronous reset with both stages full
      send_one(PW'(1 << 28), PW'(1 << 28), PW'(1 << 28));
      tick();
      #1;
      chk("pre_rst_sat_cnt", 32'(sat_cnt), 1);
      m_ready  = 1'b0;
      s_valid  = 1'b1;
      s_prod_r = PW'(50 << 21);
      s_prod_g = '0;
      s_prod_b = '0;
      tick();
      s_prod_r = PW'(51 << 21);
      tick();
      s_valid = 1'b0;
      #1;
      chk("pre_rst_full", 32'(m_valid & ~s_ready), 1);
      ap_rst_n = 1'b0;
      #1;
      chk("async_rst_m_valid", 32'(m_valid), 0);
      chk("async_rst_sat_cnt", 32'(sat_cnt), 0);
      tick();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      m_ready  = 1'b1;
      begin
         int stale;
         stale = 0;
         for (int c = 0; c < 5; c++) begin
            tick();
            if (m_valid) stale++;
         end
         chk("post_rst_no_stale", 32'(stale), 0);
         chk("post_rst_sat_cnt", 32'(sat_cnt), 0);
         chk("post_rst_s_ready", 32'(s_ready), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
